pingpong_delay: RTL

PINGPONG_DELAY -- requirements
Module: pingpong_delay

---
 rtl/pingpong_delay.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pingpong_delay.sv
// pingpong_delay: stereo delay line with feedforward, feedback, ping-pong and
// mono-in ping-pong modes. Each accepted sample walks CLEAR/IDLE -> READ -> MIX
// -> WRITE. The output strobe appears three cycles after acceptance.
module pingpong_delay #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int FEEDBACK_WIDTH = 8,
  parameter int MIX_WIDTH      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] audio_in_l,
  input  logic signed [DATA_WIDTH-1:0] audio_in_r,
  input  logic [ADDR_WIDTH-1:0]        delay_samples,
  input  logic [FEEDBACK_WIDTH-1:0]    feedback_amount,
  input  logic [MIX_WIDTH-1:0]         effect_amount,
  input  logic [1:0]                   mode,
  output logic signed [DATA_WIDTH-1:0] audio_out_l,
  output logic signed [DATA_WIDTH-1:0] audio_out_r,
  output logic                         audio_out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic signed [DATA_WIDTH-1:0] SAMPLE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAMPLE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_MIX, S_WRITE} state_t;

  // x * gain / 2^FEEDBACK_WIDTH, floor rounding; magnitude never exceeds |x|
  function automatic logic signed [DATA_WIDTH-1:0] fb_scale(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic [FEEDBACK_WIDTH-1:0]    g
  );
    logic signed [DATA_WIDTH+FEEDBACK_WIDTH:0] xe;
    logic signed [DATA_WIDTH+FEEDBACK_WIDTH:0] ge;
    logic signed [DATA_WIDTH+FEEDBACK_WIDTH:0] p;
    xe = {{(FEEDBACK_WIDTH+1){x[DATA_WIDTH-1]}}, x};
    ge = {{(DATA_WIDTH+1){1'b0}}, g};
    p  = xe * ge;
    return DATA_WIDTH'(p >>> FEEDBACK_WIDTH);
  endfunction

  // Add with clamp to the signed sample range
  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      return s[DATA_WIDTH] ? SAMPLE_MIN : SAMPLE_MAX;
    end
    return s[DATA_WIDTH-1:0];
  endfunction

  // Mono fold (l + r) / 2 with floor; always fits the sample range
  function automatic logic signed [DATA_WIDTH-1:0] mono_fold(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    return DATA_WIDTH'(s >>> 1);
  endfunction

  // Wet/dry crossfade; the two gains sum to 2^MIX_WIDTH-1 so the result cannot overflow
  function automatic logic signed [DATA_WIDTH-1:0] mix_scale(
    input logic signed [DATA_WIDTH-1:0] dry,
    input logic signed [DATA_WIDTH-1:0] wet,
    input logic [MIX_WIDTH-1:0]         e
  );
    logic signed [DATA_WIDTH+MIX_WIDTH:0] dry_e;
    logic signed [DATA_WIDTH+MIX_WIDTH:0] wet_e;
    logic signed [DATA_WIDTH+MIX_WIDTH:0] g_dry;
    logic signed [DATA_WIDTH+MIX_WIDTH:0] g_wet;
    logic signed [DATA_WIDTH+MIX_WIDTH:0] acc;
    dry_e = {{(MIX_WIDTH+1){dry[DATA_WIDTH-1]}}, dry};
    wet_e = {{(MIX_WIDTH+1){wet[DATA_WIDTH-1]}}, wet};
    g_dry = {{(DATA_WIDTH+1){1'b0}}, ~e};
    g_wet = {{(DATA_WIDTH+1){1'b0}}, e};
    acc   = dry_e * g_dry + wet_e * g_wet;
    return DATA_WIDTH'(acc >>> MIX_WIDTH);
  endfunction

  state_t r_state;
  state_t w_state_next;
  logic   w_accept;
  logic   w_mem_we;
  logic   w_mem_clr;

  logic [ADDR_WIDTH-1:0]        r_clr_addr;
  logic [ADDR_WIDTH-1:0]        r_wr_ptr;
  logic [ADDR_WIDTH-1:0]        r_cur_delay;
  logic [ADDR_WIDTH-1:0]        r_target;
  logic [FEEDBACK_WIDTH-1:0]    r_fb_gain;
  logic [MIX_WIDTH-1:0]         r_mix;
  logic [1:0]                   r_mode;
  logic                         r_overrun;
  logic                         r_out_valid;
  logic signed [DATA_WIDTH-1:0] r_in [2];

  logic [ADDR_WIDTH-1:0]        w_raddr;
  logic [ADDR_WIDTH-1:0]        w_waddr;
  logic signed [DATA_WIDTH-1:0] w_mono;
  logic signed [DATA_WIDTH-1:0] w_fb [2];
  logic signed [DATA_WIDTH-1:0] w_wval [2];
  logic signed [DATA_WIDTH-1:0] w_out [2];

  // Read tap trails the write pointer; subtraction wraps naturally
  assign w_raddr = r_wr_ptr - r_cur_delay;
  assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : r_wr_ptr;
  assign w_mono  = mono_fold(r_in[0], r_in[1]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and buffer write-port control
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_clr    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_mem_we  = ~reset;
        w_mem_clr = 1'b1;
        if (r_clr_addr == '1) w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (sample_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_READ;
        end
      end
      S_READ:  w_state_next = S_MIX;
      S_MIX:   w_state_next = S_WRITE;
      S_WRITE: begin
        w_mem_we     = ~reset;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_CLEAR;
    endcase
  end

  // Control, pointer, slew and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_addr  <= '0;
      r_wr_ptr    <= '0;
      r_cur_delay <= ONE_A;
      r_target    <= ONE_A;
      r_fb_gain   <= '0;
      r_mix       <= '0;
      r_mode      <= '0;
      r_in[0]     <= '0;
      r_in[1]     <= '0;
      r_overrun   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (r_state == S_MIX);
      if (sample_valid && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + ONE_A;
      if (w_accept) begin
        r_in[0]   <= audio_in_l;
        r_in[1]   <= audio_in_r;
        r_fb_gain <= feedback_amount;
        r_mix     <= effect_amount;
        r_mode    <= mode;
        r_target  <= (delay_samples == '0) ? ONE_A : delay_samples;
      end
      if (r_state == S_WRITE) begin
        r_wr_ptr <= r_wr_ptr + ONE_A;
        if (r_cur_delay < r_target) begin
          r_cur_delay <= r_cur_delay + ONE_A;
        end else if (r_cur_delay > r_target) begin
          r_cur_delay <= r_cur_delay - ONE_A;
        end
      end
    end
  end

  // Per-mode routing of the value written back into each buffer
  always_comb begin
    w_wval[0] = r_in[0];
    w_wval[1] = r_in[1];
    case (r_mode)
      2'b01: begin
        w_wval[0] = sat_add(r_in[0], w_fb[0]);
        w_wval[1] = sat_add(r_in[1], w_fb[1]);
      end
      2'b10: begin
        w_wval[0] = sat_add(r_in[0], w_fb[1]);
        w_wval[1] = sat_add(r_in[1], w_fb[0]);
      end
      2'b11: begin
        w_wval[0] = sat_add(w_mono, w_fb[1]);
        w_wval[1] = w_fb[0];
      end
      default: begin
        w_wval[0] = r_in[0];
        w_wval[1] = r_in[1];
      end
    endcase
  end

  // Channel 0 = left, channel 1 = right
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic signed [DATA_WIDTH-1:0] r_rd;
    logic signed [DATA_WIDTH-1:0] r_wval;
    logic signed [DATA_WIDTH-1:0] r_out;

    // Buffer write port and registered read
    always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_waddr] <= w_mem_clr ? '0 : r_wval;
      if (r_state == S_READ) r_rd <= r_mem[w_raddr];
    end

    // Capture write-back value and mixed output at the end of MIX
    always_ff @(posedge clk) begin
      if (reset) begin
        r_wval <= '0;
        r_out  <= '0;
      end else if (r_state == S_MIX) begin
        r_wval <= w_wval[gi];
        r_out  <= mix_scale(r_in[gi], r_rd, r_mix);
      end
    end

    assign w_fb[gi]  = fb_scale(r_rd, r_fb_gain);
    assign w_out[gi] = r_out;
  end

  assign audio_out_l     = w_out[0];
  assign audio_out_r     = w_out[1];
  assign audio_out_valid = r_out_valid;
  assign busy            = (r_state != S_IDLE);
  assign overrun         = r_overrun;

endmodule
